// File: rtl/alu_seq.sv
// Button-sequenced ALU: one load button steps through capture of A, B and the opcode from a
// shared bus, then one registered result with zero/carry/overflow flags is shown until the next press.
module alu_seq #(
    parameter int unsigned data_size = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic [data_size-1:0] entrada,
    output logic [data_size-1:0] result,
    output logic                 zero,
    output logic                 carry,
    output logic                 overflow,
    output logic                 valid,
    output logic [2:0]           state
);

    localparam int unsigned Msb = data_size - 1;

    localparam logic [5:0] OpSll = 6'b000000;
    localparam logic [5:0] OpSrl = 6'b000010;
    localparam logic [5:0] OpSra = 6'b000011;
    localparam logic [5:0] OpAdd = 6'b100000;
    localparam logic [5:0] OpSub = 6'b100010;
    localparam logic [5:0] OpAnd = 6'b100100;
    localparam logic [5:0] OpOr  = 6'b100101;
    localparam logic [5:0] OpXor = 6'b100110;
    localparam logic [5:0] OpNor = 6'b100111;
    localparam logic [5:0] OpSlt = 6'b101010;

    typedef enum logic [2:0] {
        StLoadA  = 3'd0,
        StLoadB  = 3'd1,
        StLoadOp = 3'd2,
        StExec   = 3'd3,
        StShow   = 3'd4
    } state_e;

    state_e                 state_q;
    logic                   load_q;
    logic [data_size-1:0]   data_a_q, data_b_q, result_q;
    logic [5:0]             op_q;
    logic                   zero_q, carry_q, overflow_q, valid_q;

    logic                   load_edge;
    logic [data_size:0]     sum, diff;
    logic                   shift_big;
    logic [data_size-1:0]   alu_res;
    logic                   alu_c, alu_v;

    assign load_edge = load & ~load_q;
    assign sum       = {1'b0, data_a_q} + {1'b0, data_b_q};
    // Top bit of the widened difference is the unsigned borrow (A < B).
    assign diff      = {1'b0, data_a_q} - {1'b0, data_b_q};
    assign shift_big = data_b_q >= data_size'(data_size);

    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (op_q)
            OpAdd: begin
                alu_res = sum[Msb:0];
                alu_c   = sum[data_size];
                alu_v   = (data_a_q[Msb] == data_b_q[Msb]) && (sum[Msb] != data_a_q[Msb]);
            end
            OpSub: begin
                alu_res = diff[Msb:0];
                alu_c   = diff[data_size];
                alu_v   = (data_a_q[Msb] != data_b_q[Msb]) && (diff[Msb] != data_a_q[Msb]);
            end
            OpAnd: alu_res = data_a_q & data_b_q;
            OpOr:  alu_res = data_a_q | data_b_q;
            OpXor: alu_res = data_a_q ^ data_b_q;
            OpNor: alu_res = ~(data_a_q | data_b_q);
            OpSrl: alu_res = shift_big ? '0 : data_a_q >> data_b_q;
            OpSra: alu_res = shift_big ? {data_size{data_a_q[Msb]}}
                                       : data_size'($signed(data_a_q) >>> data_b_q);
            OpSll: alu_res = shift_big ? '0 : data_a_q << data_b_q;
            OpSlt: alu_res = {{(data_size-1){1'b0}}, $signed(data_a_q) < $signed(data_b_q)};
            default: alu_res = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StLoadA;
            load_q     <= 1'b0;
            data_a_q   <= '0;
            data_b_q   <= '0;
            op_q       <= '0;
            result_q   <= '0;
            zero_q     <= 1'b0;
            carry_q    <= 1'b0;
            overflow_q <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            load_q <= load;
            case (state_q)
                StLoadA: if (load_edge) begin
                    data_a_q <= entrada;
                    state_q  <= StLoadB;
                end
                StLoadB: if (load_edge) begin
                    data_b_q <= entrada;
                    state_q  <= StLoadOp;
                end
                StLoadOp: if (load_edge) begin
                    op_q    <= entrada[5:0];
                    state_q <= StExec;
                end
                StExec: begin
                    result_q   <= alu_res;
                    zero_q     <= (alu_res == '0);
                    carry_q    <= alu_c;
                    overflow_q <= alu_v;
                    valid_q    <= 1'b1;
                    state_q    <= StShow;
                end
                // A press while showing starts the next sequence by capturing A immediately.
                StShow: if (load_edge) begin
                    data_a_q <= entrada;
                    valid_q  <= 1'b0;
                    state_q  <= StLoadB;
                end
                default: state_q <= StLoadA;
            endcase
        end
    end

    assign result   = result_q;
    assign zero     = zero_q;
    assign carry    = carry_q;
    assign overflow = overflow_q;
    assign valid    = valid_q;
    assign state    = state_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq: literal expectations per sequence plus a continuous check of every
// shown result against an integer-arithmetic model, for an 8-bit and a 16-bit instance.
module tb_alu_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        load, load16;
    logic [7:0]  entrada, result;
    logic [15:0] entrada16, result16;
    logic        zero, carry, overflow, valid;
    logic        zero16, carry16, overflow16, valid16;
    logic [2:0]  state, state16;

    int n_checks = 0;
    int n_fail   = 0;

    longint cur_a, cur_b, cur_a16, cur_b16;
    int     cur_op, cur_op16;

    always #5 clk = ~clk;

    alu_seq #(.data_size(8)) dut8 (
        .clk(clk), .rst(rst), .load(load), .entrada(entrada), .result(result), .zero(zero),
        .carry(carry), .overflow(overflow), .valid(valid), .state(state)
    );

    alu_seq #(.data_size(16)) dut16 (
        .clk(clk), .rst(rst), .load(load16), .entrada(entrada16), .result(result16),
        .zero(zero16), .carry(carry16), .overflow(overflow16), .valid(valid16), .state(state16)
    );

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Integer model of the ALU at width w; values are unsigned in [0, 2^w).
    function automatic void model(input int w, input longint a, input longint b, input int op,
                                  output longint r, output bit c, output bit v);
        longint m, sa, sb, s;
        m  = longint'(1) << w;
        sa = (a >= m / 2) ? a - m : a;
        sb = (b >= m / 2) ? b - m : b;
        c  = 0;
        v  = 0;
        case (op)
            32: begin
                r = (a + b) % m;
                c = (a + b) >= m;
                s = sa + sb;
                v = (s >= m / 2) || (s < -m / 2);
            end
            34: begin
                r = (a - b + m) % m;
                c = a < b;
                s = sa - sb;
                v = (s >= m / 2) || (s < -m / 2);
            end
            36: r = a & b;
            37: r = a | b;
            38: r = a ^ b;
            39: r = (m - 1) - (a | b);
            2:  r = (b >= w) ? 0 : a / (longint'(1) << b);
            3:  begin
                s = (b >= w) ? ((sa < 0) ? -1 : 0) : (sa >>> b);
                r = (s + m) % m;
            end
            0:  r = (b >= w) ? 0 : (a * (longint'(1) << b)) % m;
            42: r = (sa < sb) ? 1 : 0;
            default: r = 0;
        endcase
    endfunction

    always @(negedge clk) begin
        longint r;
        bit c, v;
        if (!rst && valid) begin
            model(8, cur_a, cur_b, cur_op, r, c, v);
            chk("model_result8", result, r);
            chk("model_zero8", zero, r == 0);
            chk("model_carry8", carry, c);
            chk("model_ovf8", overflow, v);
        end
        if (!rst && valid16) begin
            model(16, cur_a16, cur_b16, cur_op16, r, c, v);
            chk("model_result16", result16, r);
            chk("model_zero16", zero16, r == 0);
            chk("model_carry16", carry16, c);
            chk("model_ovf16", overflow16, v);
        end
    end

    task automatic press(input logic [7:0] val);
        @(negedge clk);
        entrada = val;
        load    = 1'b1;
        @(negedge clk);
        load    = 1'b0;
        entrada = 8'($urandom);
    endtask

    task automatic press16(input logic [15:0] val);
        @(negedge clk);
        entrada16 = val;
        load16    = 1'b1;
        @(negedge clk);
        load16    = 1'b0;
        entrada16 = 16'($urandom);
    endtask

    task automatic seq(input string name, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] op, input logic [7:0] er, input bit ez, input bit ec,
                       input bit ev);
        press(a);
        press(b);
        cur_a  = a;
        cur_b  = b;
        cur_op = int'(op[5:0]);
        press(op);
        chk({name, "_exec_state"}, state, 3);
        chk({name, "_exec_valid"}, valid, 0);
        @(negedge clk);
        chk({name, "_valid"}, valid, 1);
        chk({name, "_state"}, state, 4);
        chk({name, "_result"}, result, er);
        chk({name, "_zero"}, zero, ez);
        chk({name, "_carry"}, carry, ec);
        chk({name, "_ovf"}, overflow, ev);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        load      = 1'b0;
        load16    = 1'b0;
        entrada   = '0;
        entrada16 = '0;
        cur_a = 0; cur_b = 0; cur_op = 0;
        cur_a16 = 0; cur_b16 = 0; cur_op16 = 0;
        repeat (2) @(negedge clk);
        chk("rst_state", state, 0);
        chk("rst_result", result, 0);
        chk("rst_flags", {zero, carry, overflow, valid}, 0);
        rst = 1'b0;

        seq("add_ovf", 8'h7F, 8'h01, 8'h20, 8'h80, 0, 0, 1);
        seq("sub_borrow", 8'h03, 8'h05, 8'h22, 8'hFE, 0, 1, 0);
        seq("slt", 8'hFF, 8'h01, 8'h2A, 8'h01, 0, 0, 0);
        seq("sra2", 8'h90, 8'h02, 8'h03, 8'hE4, 0, 0, 0);
        seq("srl2", 8'h90, 8'h02, 8'h02, 8'h24, 0, 0, 0);
        seq("sll2", 8'h90, 8'h02, 8'h00, 8'h40, 0, 0, 0);
        seq("sra9", 8'h90, 8'h09, 8'h03, 8'hFF, 0, 0, 0);
        seq("srl9", 8'h90, 8'h09, 8'h02, 8'h00, 1, 0, 0);
        seq("add_carry", 8'hF0, 8'h20, 8'h20, 8'h10, 0, 1, 0);
        seq("xor", 8'h5A, 8'h0F, 8'h26, 8'h55, 0, 0, 0);

        // Held button: one press only, A captured.
        do_reset();
        @(negedge clk);
        entrada = 8'h11;
        load    = 1'b1;
        repeat (10) @(negedge clk);
        load    = 1'b0;
        chk("held_state", state, 1);
        press(8'h22);
        cur_a = 8'h11; cur_b = 8'h22; cur_op = 32;
        press(8'h20);
        @(negedge clk);
        chk("held_result", result, 8'h33);

        // Button held through EXEC: no capture, no skip past SHOW.
        press(8'h40);
        press(8'h02);
        cur_a = 8'h40; cur_b = 8'h02; cur_op = 32;
        @(negedge clk);
        entrada = 8'h20;
        load    = 1'b1;
        @(negedge clk);
        entrada = 8'h77;
        chk("exec_hold_state", state, 3);
        @(negedge clk);
        chk("exec_hold_show", state, 4);
        chk("exec_hold_result", result, 8'h42);
        load = 1'b0;
        repeat (2) @(negedge clk);
        chk("exec_hold_stay", state, 4);

        // Asynchronous reset while waiting for the opcode.
        press(8'h0A);
        press(8'h0B);
        chk("mid_state", state, 2);
        #2 rst = 1'b1;
        #1;
        chk("async_state", state, 0);
        chk("async_result", result, 0);
        chk("async_flags", {zero, carry, overflow, valid}, 0);
        @(negedge clk);
        rst = 1'b0;
        seq("nor_after_rst", 8'h0F, 8'hF0, 8'h27, 8'h00, 1, 0, 0);
        seq("unknown_op", 8'h5A, 8'hA5, 8'h3F, 8'h00, 1, 0, 0);

        // 16-bit instance.
        press16(16'hFFFF);
        press16(16'h0001);
        cur_a16 = 16'hFFFF; cur_b16 = 1; cur_op16 = 32;
        press16(16'h0020);
        @(negedge clk);
        chk("w16_valid", valid16, 1);
        chk("w16_result", result16, 0);
        chk("w16_carry", carry16, 1);
        chk("w16_zero", zero16, 1);
        chk("w16_ovf", overflow16, 0);

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
